muxn_reg: RTL and testbench

MUXN_REG -- requirements
Module: muxn_reg

---
 rtl/muxn_pkg.sv | 10 +
 rtl/muxn_reg_rr_arb.sv | 28 ++
 rtl/muxn_reg.sv | 111 +++++++++++
 tb/tb_muxn_reg.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/muxn_pkg.sv
// Shared constants for the N-channel registered multiplexer: default sizes and mode encoding.
package muxn_pkg;

    localparam int   W_DEFAULT  = 32;
    localparam int   N_DEFAULT  = 4;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/muxn_reg_rr_arb.sv
// Round-robin arbiter rr_arb: one-hot grant to the first requester found cyclically from ptr.
module rr_arb
    import muxn_pkg::*;
#(
    parameter int N  = N_DEFAULT,
    parameter int SW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic [N-1:0]  grant
);

    always_comb begin
        logic found;
        found = 1'b0;
        grant = '0;
        // Offset k = 0 is the highest-priority position, so the outer loop walks priority order.
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!found && req[i] && (i == (int'(ptr) + k) % N)) begin
                    grant[i] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/muxn_reg.sv
// N-to-1 multiplexer with a single-entry registered output and ready/valid handshakes.
// Round-robin selection is compiled in only when MUXN_REG_RR_EN is defined.
module muxn_reg
    import muxn_pkg::*;
#(
    parameter int W  = W_DEFAULT,
    parameter int N  = N_DEFAULT,
    parameter int SW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N*W-1:0]  in_data,
    input  logic [N-1:0]    in_valid,
    output logic [N-1:0]    in_ready,
    input  logic [SW-1:0]   sel,
    input  logic            mode,
    output logic [W-1:0]    out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SW-1:0]   out_chan
);

    logic          r_vld_p1;
    logic [W-1:0]  r_data_p1;
    logic [SW-1:0] r_chan_p1;

    logic          w_load;
    logic          w_xfer;
    logic [N-1:0]  w_fix_grant;
    logic [N-1:0]  w_grant;
    logic [SW-1:0] w_gidx;
    logic [W-1:0]  w_din;

    assign w_load = !r_vld_p1 || out_ready;

    // An out-of-range select matches no channel, leaving every ready low.
    always_comb begin
        w_fix_grant = '0;
        for (int i = 0; i < N; i++) begin
            if (int'(sel) == i) begin
                w_fix_grant[i] = 1'b1;
            end
        end
    end

`ifdef MUXN_REG_RR_EN
    logic [SW-1:0] r_ptr;
    logic [N-1:0]  w_rr_grant;

    rr_arb #(
        .N  (N),
        .SW (SW)
    ) u_rr_arb (
        .req   (in_valid),
        .ptr   (r_ptr),
        .grant (w_rr_grant)
    );

    assign w_grant = (mode == MODE_RR) ? w_rr_grant : w_fix_grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_xfer && (mode == MODE_RR)) begin
            if (int'(w_gidx) == N - 1) begin
                r_ptr <= '0;
            end else begin
                r_ptr <= w_gidx + 1'b1;
            end
        end
    end
`else
    logic w_unused_mode;
    assign w_unused_mode = mode;
    assign w_grant       = w_fix_grant;
`endif

    assign in_ready = (rst || !w_load) ? '0 : w_grant;
    assign w_xfer   = |(in_valid & in_ready);

    always_comb begin
        w_gidx = '0;
        w_din  = '0;
        for (int i = 0; i < N; i++) begin
            if (in_ready[i]) begin
                w_gidx = SW'(i);
                w_din  = in_data[i*W +: W];
            end
        end
    end

    // Output register stage: a transfer always wins over a pop, giving 1 beat/cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_p1  <= 1'b0;
            r_data_p1 <= '0;
            r_chan_p1 <= '0;
        end else if (w_xfer) begin
            r_vld_p1  <= 1'b1;
            r_data_p1 <= w_din;
            r_chan_p1 <= w_gidx;
        end else if (out_ready) begin
            r_vld_p1  <= 1'b0;
        end
    end

    assign out_data  = r_data_p1;
    assign out_valid = r_vld_p1;
    assign out_chan  = r_chan_p1;

endmodule

// File: tb/tb_muxn_reg.sv
// Bench for muxn_reg: directed scenarios plus random traffic against a behavioural model.
module tb_muxn_reg;

    localparam int W  = 16;
    localparam int N  = 4;
    localparam int SW = 3;
`ifdef MUXN_REG_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N*W-1:0]  in_data = '0;
    logic [N-1:0]    in_valid = '0;
    logic [N-1:0]    in_ready;
    logic [SW-1:0]   sel = '0;
    logic            mode = 1'b0;
    logic [W-1:0]    out_data;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [SW-1:0]   out_chan;

    muxn_reg #(.W(W), .N(N), .SW(SW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .mode      (mode),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_chan  (out_chan)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference state: what the output register and rotation pointer should hold.
    bit          m_vld  = 1'b0;
    logic [W-1:0] m_data = '0;
    int          m_chan = 0;
    int          m_ptr  = 0;
    bit          last_xfer = 1'b0;
    int          last_g    = -1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic int model_grant();
        if (RR && mode) begin
            for (int k = 0; k < N; k++) begin
                if (in_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
            end
            return -1;
        end
        return (int'(sel) < N) ? int'(sel) : -1;
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, ".out_valid"}, 64'(out_valid), 64'(m_vld));
        check({tag, ".out_data"},  64'(out_data),  64'(m_data));
        check({tag, ".out_chan"},  64'(out_chan),  64'(m_chan));
    endtask

    // Called just after a falling edge with inputs already driven; returns just after the next falling edge.
    task automatic cycle(input string tag);
        int           g;
        bit           load;
        logic [N-1:0] exp_rdy;
        #1;
        load    = !m_vld || out_ready;
        g       = model_grant();
        exp_rdy = '0;
        if (load && g >= 0) exp_rdy[g] = 1'b1;
        check({tag, ".in_ready"}, 64'(in_ready), 64'(exp_rdy));
        @(posedge clk);
        last_xfer = (exp_rdy != '0) && in_valid[g];
        last_g    = g;
        if (last_xfer) begin
            m_vld  = 1'b1;
            m_data = in_data[g*W +: W];
            m_chan = g;
            if (RR && mode) m_ptr = (g + 1) % N;
        end else if (out_ready) begin
            m_vld = 1'b0;
        end
        #1;
        check_outputs(tag);
        @(negedge clk);
    endtask

    task automatic pulse_reset(input string tag);
        @(negedge clk);
        #2 rst = 1'b1;
        m_vld = 1'b0; m_data = '0; m_chan = 0; m_ptr = 0;
        #1;
        check_outputs({tag, ".async"});
        check({tag, ".in_ready_rst"}, 64'(in_ready), 64'h0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        in_valid = '1;
        // Reset state while held in reset from time zero.
        #3;
        check_outputs("reset");
        check("reset.in_ready", 64'(in_ready), 64'h0);
        @(negedge clk);
        rst = 1'b0;

        // Fixed select stepping through channels with constant data 1..4.
        for (int i = 0; i < N; i++) in_data[i*W +: W] = W'(i + 1);
        out_ready = 1'b1;
        mode      = 1'b0;
        for (int s = 0; s < N; s++) begin
            sel = SW'(s);
            for (int c = 0; c < 10; c++) cycle("fixed");
        end

        // Backpressure holds the buffered beat, then release loads the next one.
        for (int i = 0; i < N; i++) in_data[i*W +: W] = W'($urandom);
        sel = 3'd2;
        cycle("bp.load");
        out_ready = 1'b0;
        sel = 3'd1;
        for (int c = 0; c < 5; c++) cycle("bp.hold");
        out_ready = 1'b1;
        sel = 3'd3;
        cycle("bp.release");
        check("bp.release_chan", 64'(out_chan), 64'd3);

        // Out-of-range select grants nothing.
        sel = 3'd5;
        for (int c = 0; c < 4; c++) cycle("sel_oob");
        check("sel_oob.valid", 64'(out_valid), 64'd0);

        // Round-robin with every channel valid, then only channels 1 and 3.
        mode = 1'b1;
        sel  = 3'd0;
        for (int c = 0; c < 8; c++) cycle("rr.all");
        in_valid = 4'b1010;
        for (int c = 0; c < 8; c++) cycle("rr.sparse");

        // Mid-stream reset discards the buffered beat and restarts rotation.
        in_valid = '1;
        for (int c = 0; c < 3; c++) cycle("pre_rst");
        pulse_reset("mid_rst");
        for (int c = 0; c < 6; c++) cycle("post_rst");

        // Random traffic; sources keep valid and data until their beat transfers.
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!in_valid[i] || (last_xfer && last_g == i)) begin
                    in_valid[i]       = ($urandom_range(0, 3) != 0);
                    in_data[i*W +: W] = W'($urandom);
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) mode = ~mode;
            if ($urandom_range(0, 3) == 0) sel = SW'($urandom_range(0, 7));
            cycle("rand");
            if (c == 150) pulse_reset("rand_rst");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
